ahb_regfile_slave: RTL and testbench

- Parametrised AHB-Lite slave.
- Holds a bank of NUM_REGS registers of DATA_W bits, addressed by haddr.
- Supports reads and writes, a programmable number of wait states, and the two-cycle ERROR response.
- Register 0 is a saturating error counter; a write to it clears it.
- Sits behind the AHB decoder/mux as a generic peripheral register block; it replaces the fixed 8-bit read-only slave.

---
 rtl/ahb_pkg.sv | 39 +++
 rtl/ahb_reg_bank.sv | 40 ++++
 rtl/ahb_regfile_slave.sv | 180 ++++++++++++++++++
 tb/tb_ahb_regfile_slave.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/ahb_pkg.sv
// Shared AHB-Lite types for the register-file slave: transfer types, size codes,
// response codes, slave data-phase states and the byte-lane helper.
package ahb_pkg;

   typedef enum logic [1:0] {
      HTRANS_IDLE   = 2'd0,
      HTRANS_BUSY   = 2'd1,
      HTRANS_NONSEQ = 2'd2,
      HTRANS_SEQ    = 2'd3
   } htrans_t;

   localparam logic [2:0] HSIZE_BYTE  = 3'd0;
   localparam logic [2:0] HSIZE_HWORD = 3'd1;
   localparam logic [2:0] HSIZE_WORD  = 3'd2;
   localparam logic [2:0] HSIZE_DWORD = 3'd3;

   localparam logic HRESP_OKAY  = 1'b0;
   localparam logic HRESP_ERROR = 1'b1;

   localparam logic [7:0] ERR_CNT_MAX = 8'hFF;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_WAIT = 3'd1,
      ST_DONE = 3'd2,
      ST_ERR1 = 3'd3,
      ST_ERR2 = 3'd4
   } slv_state_t;

   // Byte lanes touched by a transfer of 2**size bytes starting at lane offset.
   function automatic logic [7:0] lane_mask(input logic [2:0] size, input logic [2:0] offset);
      logic [3:0]  nbytes;
      logic [15:0] span;
      nbytes = 4'd1 << size;
      span   = (16'd1 << nbytes) - 16'd1;
      return span[7:0] << offset;
   endfunction

endpackage

// File: rtl/ahb_reg_bank.sv
// Register array for the AHB register-file slave: byte-lane write enables and
// an asynchronous read mux; all registers clear on reset.
module ahb_reg_bank
   import ahb_pkg::*;
#(
   parameter int DATA_W   = 32,
   parameter int NUM_REGS = 8
) (
   input  logic                        hclk,
   input  logic                        hreset_n,
   input  logic                        we,
   input  logic [DATA_W/8-1:0]         wstrb,
   input  logic [$clog2(NUM_REGS)-1:0] widx,
   input  logic [DATA_W-1:0]           wdata,
   input  logic [$clog2(NUM_REGS)-1:0] ridx,
   output logic [DATA_W-1:0]           rdata
);

   localparam int BYTES = DATA_W / 8;

   logic [DATA_W-1:0] regs_r [NUM_REGS];

   // Register storage, written lane by lane.
   always_ff @(posedge hclk) begin
      if (!hreset_n) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            regs_r[i] <= '0;
         end
      end else if (we) begin
         for (int b = 0; b < BYTES; b++) begin
            if (wstrb[b]) begin
               regs_r[widx][b*8 +: 8] <= wdata[b*8 +: 8];
            end
         end
      end
   end

   assign rdata = regs_r[ridx];

endmodule

// File: rtl/ahb_regfile_slave.sv
// Parametrised AHB-Lite register-file slave with wait states, ERROR response and
// a saturating error counter at register 0. Sub-word writes: AHB_SLV_BYTE_STROBE_EN.
module ahb_regfile_slave
   import ahb_pkg::*;
#(
   parameter int DATA_W      = 32,
   parameter int NUM_REGS    = 8,
   parameter int WAIT_STATES = 0
) (
   input  logic              hclk,
   input  logic              hreset_n,
   input  logic              hsel,
   input  logic [31:0]       haddr,
   input  logic [1:0]        htrans,
   input  logic              hwrite,
   input  logic [2:0]        hsize,
   input  logic [DATA_W-1:0] hwdata,
   input  logic              hready,
   output logic              hreadyout,
   output logic [DATA_W-1:0] hrdata,
   output logic              hresp
);

   localparam int         BYTES     = DATA_W / 8;
   localparam int         ADDR_LSB  = $clog2(BYTES);
   localparam int         IDX_W     = $clog2(NUM_REGS);
   localparam logic [2:0] MAX_SIZE  = 3'(ADDR_LSB);
   localparam logic [2:0] WAIT_LOAD = 3'((WAIT_STATES > 0) ? (WAIT_STATES - 1) : 0);

   htrans_t           trans_s;
   slv_state_t        state_r, state_nxt_s;
   logic              take_s, err_s, rd_write_s;
   logic [31:0]       idx_full_s;
   logic [IDX_W-1:0]  addr_idx_s, idx_r, rd_idx_s;
   logic [7:0]        align_mask_s;
   logic [BYTES-1:0]  strb_s, strb_r;
   logic              write_r;
   logic [2:0]        wait_cnt_r;
   logic [7:0]        err_cnt_r, err_cnt_nxt_s;
   logic              cnt_clr_s, bank_we_s, fwd_s, load_rdata_s;
   logic [DATA_W-1:0] bank_rdata_s, wmask_s, rd_word_s, hrdata_r;
   logic              hreadyout_r, hresp_r;

   assign trans_s    = htrans_t'(htrans);
   assign idx_full_s = haddr >> ADDR_LSB;
   assign addr_idx_s = idx_full_s[IDX_W-1:0];
   assign take_s     = hsel && hready
                       && ((trans_s == HTRANS_NONSEQ) || (trans_s == HTRANS_SEQ))
                       && ((state_r == ST_IDLE) || (state_r == ST_DONE) || (state_r == ST_ERR2));

   // Address-phase decode: error classification and byte lanes.
   always_comb begin
      align_mask_s = (8'd1 << hsize) - 8'd1;
      err_s        = 1'b0;
      if ((idx_full_s >> IDX_W) != 32'd0) begin
         err_s = 1'b1;
      end else if (hsize > MAX_SIZE) begin
         err_s = 1'b1;
      end else if ((haddr[7:0] & align_mask_s) != 8'd0) begin
         err_s = 1'b1;
`ifdef AHB_SLV_BYTE_STROBE_EN
      end else begin
         err_s = 1'b0;
      end
      strb_s = BYTES'(lane_mask(hsize, haddr[2:0] & 3'(BYTES - 1)));
`else
      end else if (hsize < MAX_SIZE) begin
         err_s = 1'b1;
      end else begin
         err_s = 1'b0;
      end
      strb_s = '1;
`endif
   end

   // Data-phase sequencing.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         ST_IDLE, ST_DONE, ST_ERR2: begin
            if (!take_s) begin
               state_nxt_s = ST_IDLE;
            end else if (err_s) begin
               state_nxt_s = ST_ERR1;
            end else if (WAIT_STATES > 0) begin
               state_nxt_s = ST_WAIT;
            end else begin
               state_nxt_s = ST_DONE;
            end
         end
         ST_WAIT: begin
            if (wait_cnt_r == 3'd0) begin
               state_nxt_s = ST_DONE;
            end else begin
               state_nxt_s = ST_WAIT;
            end
         end
         ST_ERR1: state_nxt_s = ST_ERR2;
         default: state_nxt_s = ST_IDLE;
      endcase
   end

   // Write strobes, counter update and the read word with write forwarding.
   always_comb begin
      wmask_s = '0;
      for (int b = 0; b < BYTES; b++) begin
         wmask_s[b*8 +: 8] = {8{strb_r[b]}};
      end
      bank_we_s = (state_r == ST_DONE) && write_r && (idx_r != IDX_W'(0)) && hreset_n;
      cnt_clr_s = (state_r == ST_DONE) && write_r && (idx_r == IDX_W'(0));
      if (cnt_clr_s) begin
         err_cnt_nxt_s = 8'd0;
      end else if ((state_r == ST_ERR2) && (err_cnt_r != ERR_CNT_MAX)) begin
         err_cnt_nxt_s = err_cnt_r + 8'd1;
      end else begin
         err_cnt_nxt_s = err_cnt_r;
      end
      rd_idx_s     = take_s ? addr_idx_s : idx_r;
      rd_write_s   = take_s ? hwrite : write_r;
      load_rdata_s = (state_nxt_s == ST_DONE) && !rd_write_s;
      fwd_s        = (state_r == ST_DONE) && write_r && (idx_r == rd_idx_s);
      if (rd_idx_s == IDX_W'(0)) begin
         rd_word_s = DATA_W'(err_cnt_nxt_s);
      end else if (fwd_s) begin
         rd_word_s = (bank_rdata_s & ~wmask_s) | (hwdata & wmask_s);
      end else begin
         rd_word_s = bank_rdata_s;
      end
   end

   // State, captured address phase, counters and registered bus outputs.
   always_ff @(posedge hclk) begin
      if (!hreset_n) begin
         state_r     <= ST_IDLE;
         idx_r       <= '0;
         write_r     <= 1'b0;
         strb_r      <= '0;
         wait_cnt_r  <= 3'd0;
         err_cnt_r   <= 8'd0;
         hreadyout_r <= 1'b1;
         hresp_r     <= HRESP_OKAY;
         hrdata_r    <= '0;
      end else begin
         state_r     <= state_nxt_s;
         err_cnt_r   <= err_cnt_nxt_s;
         hreadyout_r <= !((state_nxt_s == ST_WAIT) || (state_nxt_s == ST_ERR1));
         hresp_r     <= ((state_nxt_s == ST_ERR1) || (state_nxt_s == ST_ERR2)) ? HRESP_ERROR : HRESP_OKAY;
         if (take_s) begin
            idx_r      <= addr_idx_s;
            write_r    <= hwrite;
            strb_r     <= strb_s;
            wait_cnt_r <= WAIT_LOAD;
         end else if ((state_r == ST_WAIT) && (wait_cnt_r != 3'd0)) begin
            wait_cnt_r <= wait_cnt_r - 3'd1;
         end
         if (load_rdata_s) begin
            hrdata_r <= rd_word_s;
         end
      end
   end

   ahb_reg_bank #(
      .DATA_W   (DATA_W),
      .NUM_REGS (NUM_REGS)
   ) u_bank (
      .hclk     (hclk),
      .hreset_n (hreset_n),
      .we       (bank_we_s),
      .wstrb    (strb_r),
      .widx     (idx_r),
      .wdata    (hwdata),
      .ridx     (rd_idx_s),
      .rdata    (bank_rdata_s)
   );

   assign hreadyout = hreadyout_r;
   assign hresp     = hresp_r;
   assign hrdata    = hrdata_r;

endmodule

// File: tb/tb_ahb_regfile_slave.sv
// Directed bench for ahb_regfile_slave: one zero-wait and one 3-wait instance on
// a shared bus, a vector table plus hand-written pipelined and reset sequences.
module tb_ahb_regfile_slave;

`ifdef AHB_SLV_BYTE_STROBE_EN
   localparam bit STRB = 1'b1;
`else
   localparam bit STRB = 1'b0;
`endif

   logic        hclk = 1'b0;
   logic        hreset_n, hsel, hwrite, blk, sel;
   logic [31:0] haddr, hwdata;
   logic [1:0]  htrans;
   logic [2:0]  hsize;
   logic        hsel0, hsel3, hready, ho0, ho3, hr0, hr3, ho_m, hr_m;
   logic [31:0] rd0, rd3, rd_m;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 hclk = ~hclk;

   assign hsel0  = hsel & ~sel;
   assign hsel3  = hsel & sel;
   assign ho_m   = sel ? ho3 : ho0;
   assign hr_m   = sel ? hr3 : hr0;
   assign rd_m   = sel ? rd3 : rd0;
   assign hready = ho_m & ~blk;

   ahb_regfile_slave #(.DATA_W(32), .NUM_REGS(8), .WAIT_STATES(0)) dut0 (
      .hclk(hclk), .hreset_n(hreset_n), .hsel(hsel0), .haddr(haddr), .htrans(htrans),
      .hwrite(hwrite), .hsize(hsize), .hwdata(hwdata), .hready(hready),
      .hreadyout(ho0), .hrdata(rd0), .hresp(hr0));

   ahb_regfile_slave #(.DATA_W(32), .NUM_REGS(8), .WAIT_STATES(3)) dut3 (
      .hclk(hclk), .hreset_n(hreset_n), .hsel(hsel3), .haddr(haddr), .htrans(htrans),
      .hwrite(hwrite), .hsize(hsize), .hwdata(hwdata), .hready(hready),
      .hreadyout(ho3), .hrdata(rd3), .hresp(hr3));

   typedef struct {
      logic        wr;
      logic [31:0] addr;
      logic [2:0]  size;
      logic [31:0] wdata;
      logic        err;
      logic [31:0] rdata;
   } vec_t;

   vec_t vecs[16];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // One non-pipelined transfer; returns at the negedge of the last data-phase cycle.
   task automatic xfer(input logic s, input logic w, input logic [31:0] a, input logic [2:0] sz,
                       input logic [31:0] wd, output logic resp, output logic [31:0] rd,
                       output int lo, output logic lo_resp);
      @(negedge hclk);
      sel = s; hsel = 1'b1; htrans = 2'b10; haddr = a; hwrite = w; hsize = sz;
      @(negedge hclk);
      hsel = 1'b0; htrans = 2'b00; hwdata = wd;
      lo = 0; lo_resp = 1'b0;
      while (ho_m !== 1'b1 && lo < 20) begin
         if (lo == 0) lo_resp = hr_m;
         lo++;
         @(negedge hclk);
      end
      resp = hr_m;
      rd   = rd_m;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic        resp, lo_resp;
      logic [31:0] rd;
      int          lo;

      vecs[0]  = '{1'b1, 32'h08, 3'd2, 32'hDEADBEEF, 1'b0, 32'h0};
      vecs[1]  = '{1'b0, 32'h08, 3'd2, 32'h0,        1'b0, 32'hDEADBEEF};
      vecs[2]  = '{1'b0, 32'h40, 3'd2, 32'h0,        1'b1, 32'h0};
      vecs[3]  = '{1'b0, 32'h00, 3'd2, 32'h0,        1'b0, 32'h1};
      vecs[4]  = '{1'b1, 32'h05, 3'd0, 32'h0000AA00, !STRB, 32'h0};
      vecs[5]  = '{1'b0, 32'h04, 3'd2, 32'h0,        1'b0, STRB ? 32'h0000AA00 : 32'h0};
      vecs[6]  = '{1'b0, 32'h00, 3'd2, 32'h0,        1'b0, STRB ? 32'h1 : 32'h2};
      vecs[7]  = '{1'b1, 32'h06, 3'd2, 32'h11111111, 1'b1, 32'h0};
      vecs[8]  = '{1'b0, 32'h00, 3'd3, 32'h0,        1'b1, 32'h0};
      vecs[9]  = '{1'b1, 32'h1C, 3'd2, 32'hCAFEF00D, 1'b0, 32'h0};
      vecs[10] = '{1'b0, 32'h1C, 3'd2, 32'h0,        1'b0, 32'hCAFEF00D};
      vecs[11] = '{1'b0, 32'h20, 3'd2, 32'h0,        1'b1, 32'h0};
      vecs[12] = '{1'b0, 32'h00, 3'd2, 32'h0,        1'b0, STRB ? 32'h4 : 32'h5};
      vecs[13] = '{1'b1, 32'h00, 3'd2, 32'hFFFFFFFF, 1'b0, 32'h0};
      vecs[14] = '{1'b0, 32'h00, 3'd2, 32'h0,        1'b0, 32'h0};
      vecs[15] = '{1'b0, 32'h08, 3'd2, 32'h0,        1'b0, 32'hDEADBEEF};

      hreset_n = 1'b0; hsel = 1'b0; hwrite = 1'b0; blk = 1'b0; sel = 1'b0;
      haddr = 32'h0; hwdata = 32'h0; htrans = 2'b00; hsize = 3'd2;
      repeat (3) @(negedge hclk);
      chk("reset hreadyout0", ho0, 1'b1);
      chk("reset hresp0",     hr0, 1'b0);
      chk("reset hrdata0",    rd0, 32'h0);
      chk("reset hreadyout3", ho3, 1'b1);
      chk("reset hrdata3",    rd3, 32'h0);
      hreset_n = 1'b1;

      for (int i = 0; i < 16; i++) begin
         xfer(1'b0, vecs[i].wr, vecs[i].addr, vecs[i].size, vecs[i].wdata, resp, rd, lo, lo_resp);
         chk($sformatf("vec%0d hresp", i), resp, vecs[i].err);
         chk($sformatf("vec%0d wait", i), lo, vecs[i].err ? 1 : 0);
         if (vecs[i].err) chk($sformatf("vec%0d err1 hresp", i), lo_resp, 1'b1);
         else if (!vecs[i].wr) chk($sformatf("vec%0d hrdata", i), rd, vecs[i].rdata);
      end

      // back-to-back write then read of 0xC: read data forwarded from hwdata
      @(negedge hclk);
      sel = 1'b0; hsel = 1'b1; htrans = 2'b10; haddr = 32'hC; hwrite = 1'b1; hsize = 3'd2;
      @(negedge hclk);
      chk("fwd write done", ho0, 1'b1);
      hwdata = 32'h12345678; hwrite = 1'b0;
      @(negedge hclk);
      hsel = 1'b0; htrans = 2'b00;
      chk("fwd read ready", ho0, 1'b1);
      chk("fwd read hresp", hr0, 1'b0);
      chk("fwd read hrdata", rd0, 32'h12345678);

      // error then a read of reg 0 accepted on the ERR2 cycle
      @(negedge hclk);
      hsel = 1'b1; htrans = 2'b10; haddr = 32'h40; hwrite = 1'b0;
      @(negedge hclk);
      hsel = 1'b0; htrans = 2'b00;
      chk("err1 hreadyout", ho0, 1'b0);
      chk("err1 hresp", hr0, 1'b1);
      @(negedge hclk);
      chk("err2 hreadyout", ho0, 1'b1);
      chk("err2 hresp", hr0, 1'b1);
      hsel = 1'b1; htrans = 2'b10; haddr = 32'h0;
      @(negedge hclk);
      hsel = 1'b0; htrans = 2'b00;
      chk("cnt after err2 hresp", hr0, 1'b0);
      chk("cnt after err2 hrdata", rd0, 32'h1);

      // saturation: 256 more errors, then clear
      for (int i = 0; i < 256; i++) begin
         xfer(1'b0, 1'b0, 32'h40, 3'd2, 32'h0, resp, rd, lo, lo_resp);
      end
      xfer(1'b0, 1'b0, 32'h0, 3'd2, 32'h0, resp, rd, lo, lo_resp);
      chk("cnt saturated", rd, 32'hFF);
      xfer(1'b0, 1'b1, 32'h0, 3'd2, 32'h5A, resp, rd, lo, lo_resp);
      chk("cnt clear hresp", resp, 1'b0);
      xfer(1'b0, 1'b0, 32'h0, 3'd2, 32'h0, resp, rd, lo, lo_resp);
      chk("cnt cleared", rd, 32'h0);

      // hready held low by another slave: no address phase accepted
      @(negedge hclk);
      sel = 1'b0; blk = 1'b1; hsel = 1'b1; htrans = 2'b10; haddr = 32'h10; hwrite = 1'b1;
      @(negedge hclk);
      blk = 1'b0; hsel = 1'b0; htrans = 2'b00; hwdata = 32'h0BADF00D;
      chk("hready low hreadyout", ho0, 1'b1);
      chk("hready low hresp", hr0, 1'b0);
      xfer(1'b0, 1'b0, 32'h10, 3'd2, 32'h0, resp, rd, lo, lo_resp);
      chk("hready low no write", rd, 32'h0);

      // three wait states
      xfer(1'b1, 1'b1, 32'h4, 3'd2, 32'h5A5A1234, resp, rd, lo, lo_resp);
      chk("ws3 write wait", lo, 3);
      chk("ws3 write hresp", resp, 1'b0);
      xfer(1'b1, 1'b0, 32'h4, 3'd2, 32'h0, resp, rd, lo, lo_resp);
      chk("ws3 read wait", lo, 3);
      chk("ws3 read hresp", resp, 1'b0);
      chk("ws3 read hrdata", rd, 32'h5A5A1234);
      xfer(1'b1, 1'b0, 32'h40, 3'd2, 32'h0, resp, rd, lo, lo_resp);
      chk("ws3 error wait", lo, 1);
      chk("ws3 error hresp", resp, 1'b1);

      // reset during WAIT aborts the write
      @(negedge hclk);
      sel = 1'b1; hsel = 1'b1; htrans = 2'b10; haddr = 32'h8; hwrite = 1'b1;
      @(negedge hclk);
      hsel = 1'b0; htrans = 2'b00; hwdata = 32'h11112222;
      chk("ws3 in wait", ho3, 1'b0);
      hreset_n = 1'b0;
      @(negedge hclk);
      chk("abort hreadyout", ho3, 1'b1);
      chk("abort hresp", hr3, 1'b0);
      chk("abort hrdata", rd3, 32'h0);
      hreset_n = 1'b1;
      xfer(1'b1, 1'b0, 32'h8, 3'd2, 32'h0, resp, rd, lo, lo_resp);
      chk("abort nothing written", rd, 32'h0);
      xfer(1'b1, 1'b0, 32'h4, 3'd2, 32'h0, resp, rd, lo, lo_resp);
      chk("abort regs cleared", rd, 32'h0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
